// File: rtl/soft_mem_pkg.sv
// Shared definitions for the soft associative memory controller:
// controller state encoding, default geometry and response flag positions.
package soft_mem_pkg;

  localparam int DEF_BIT_WIDTH     = 512;
  localparam int DEF_NUM_CELLS     = 16;
  localparam int DEF_LOG_NUM_CELLS = 4;
  localparam int DEF_TIMEOUT       = 15;
  localparam int DEF_TIMEOUT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ALLOC = 3'd3,
    ST_RESP  = 3'd4
  } ctrl_state_t;

  // Bit positions inside the registered response flag vector.
  localparam int FLAG_HIT     = 0;
  localparam int FLAG_MULTI   = 1;
  localparam int FLAG_ALLOC   = 2;
  localparam int FLAG_FULL    = 3;
  localparam int FLAG_TIMEOUT = 4;
  localparam int FLAG_W       = 5;

endpackage

// File: rtl/lowest_one_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest 1 in vec and a
// found flag. idx is 0 when vec is all zeros.
module lowest_one_enc #(
  parameter int N     = 16,
  parameter int LOG_N = 4
) (
  input  logic [N-1:0]     vec,
  output logic [LOG_N-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = LOG_N'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soft_mem_controller.sv
// Initiator/arbiter for an array of soft associative memory cells.
// Broadcasts a host query to all cells, resolves unique/multi hits and
// misses, allocates the lowest empty cell on a write miss and returns one
// response per request.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE; resp_valid is high only in
// RESP and the response fields stay stable until resp_ready is seen.
//
// Optional build macro SOFT_MEM_CTRL_TIMEOUT_EN adds a WAIT-state timeout
// counter and the resp_timeout output.
module soft_mem_controller
  import soft_mem_pkg::*;
#(
  parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int NUM_CELLS     = DEF_NUM_CELLS,
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
`endif
  parameter int LOG_NUM_CELLS = DEF_LOG_NUM_CELLS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_wnr,
  input  logic [BIT_WIDTH-1:0]           req_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [BIT_WIDTH-1:0]           resp_data,
  output logic                           resp_hit,
  output logic                           resp_multi,
  output logic                           resp_alloc,
  output logic                           resp_full,
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
  output logic                           resp_timeout,
`endif
  output logic [LOG_NUM_CELLS-1:0]       resp_index,
  output logic [BIT_WIDTH-1:0]           cell_address,
  output logic                           cell_valid,
  output logic                           cell_wnr,
  output logic [NUM_CELLS-1:0]           cell_set_address,
  output logic [NUM_CELLS-1:0]           cell_other_hit,
  input  logic [NUM_CELLS-1:0]           cell_hit,
  input  logic [NUM_CELLS-1:0]           cell_decision_valid,
  input  logic [NUM_CELLS-1:0]           cell_location_empty,
  input  logic [NUM_CELLS*BIT_WIDTH-1:0] cell_rdata,
  output logic [2:0]                     dbg_state
);

`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
  localparam int NFLAGS = FLAG_W;
`else
  localparam int NFLAGS = FLAG_TIMEOUT;
`endif

  ctrl_state_t state_q, state_d;

  logic [BIT_WIDTH-1:0]     addr_q;
  logic                     wnr_q;
  logic [NFLAGS-1:0]        flags_q;
  logic [LOG_NUM_CELLS-1:0] index_q;
  logic [BIT_WIDTH-1:0]     data_q;

  logic [LOG_NUM_CELLS-1:0] hit_idx, empty_idx;
  logic                     hit_found, empty_found;
  logic                     decision;
  logic                     multi_hit;
  logic                     do_alloc;
  logic [BIT_WIDTH-1:0]     hit_data;

`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wait_cnt_q;
  logic                     wait_expired;
  assign wait_expired = (wait_cnt_q == TIMEOUT_WIDTH'(TIMEOUT - 1));
`endif

  lowest_one_enc #(.N(NUM_CELLS), .LOG_N(LOG_NUM_CELLS)) u_hit_enc (
    .vec   (cell_hit),
    .idx   (hit_idx),
    .found (hit_found)
  );

  lowest_one_enc #(.N(NUM_CELLS), .LOG_N(LOG_NUM_CELLS)) u_empty_enc (
    .vec   (cell_location_empty),
    .idx   (empty_idx),
    .found (empty_found)
  );

  assign decision  = (state_q == ST_WAIT) && (|cell_decision_valid);
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_hit = |(cell_hit & (cell_hit - NUM_CELLS'(1)));
  assign do_alloc  = wnr_q && !hit_found && empty_found;

  // Read data of the lowest hitting cell.
  always_comb begin
    hit_data = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (hit_idx == LOG_NUM_CELLS'(i)) hit_data = cell_rdata[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    cell_valid       = 1'b0;
    cell_set_address = '0;
    cell_other_hit   = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cell_valid = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (decision) begin
          for (int i = 0; i < NUM_CELLS; i++) begin
            cell_other_hit[i] = |(cell_hit & ~(NUM_CELLS'(1) << i));
          end
          state_d = do_alloc ? ST_ALLOC : ST_RESP;
        end
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
        else if (wait_expired) begin
          state_d = ST_RESP;
        end
`endif
      end
      ST_ALLOC: begin
        cell_set_address = NUM_CELLS'(1) << index_q;
        state_d          = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wnr_q   <= 1'b0;
      flags_q <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            wnr_q  <= req_wnr;
          end
        end
        ST_WAIT: begin
          if (decision) begin
            flags_q[FLAG_HIT]   <= hit_found;
            flags_q[FLAG_MULTI] <= multi_hit;
            flags_q[FLAG_FULL]  <= wnr_q && !hit_found && !empty_found;
            index_q             <= do_alloc ? empty_idx : hit_idx;
            data_q              <= hit_found ? hit_data : '0;
          end
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
          else if (wait_expired) begin
            flags_q[FLAG_TIMEOUT] <= 1'b1;
          end
`endif
        end
        ST_ALLOC: flags_q[FLAG_ALLOC] <= 1'b1;
        ST_RESP: begin
          if (resp_ready) begin
            flags_q <= '0;
            index_q <= '0;
            data_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
  // Cycles spent in WAIT for the current query; restarted on every issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        wait_cnt_q <= '0;
    else if (state_q == ST_ISSUE)                   wait_cnt_q <= '0;
    else if (state_q == ST_WAIT && !wait_expired)   wait_cnt_q <= wait_cnt_q + TIMEOUT_WIDTH'(1);
  end
  assign resp_timeout = flags_q[FLAG_TIMEOUT];
`endif

  assign cell_address = addr_q;
  assign cell_wnr     = wnr_q;
  assign resp_hit     = flags_q[FLAG_HIT];
  assign resp_multi   = flags_q[FLAG_MULTI];
  assign resp_alloc   = flags_q[FLAG_ALLOC];
  assign resp_full    = flags_q[FLAG_FULL];
  assign resp_index   = index_q;
  assign resp_data    = data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_soft_mem_controller.sv
// Bench for soft_mem_controller with 4 cells and a one-cycle cell decision
// latency. Expected responses come from a rule-level reference model.
module tb_soft_mem_controller;

  localparam int BW  = 64;
  localparam int NC  = 4;
  localparam int LNC = 2;
  localparam int EW  = 4 + LNC + BW;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_wnr;
  logic [BW-1:0]   req_addr;
  logic            resp_valid, resp_ready;
  logic [BW-1:0]   resp_data;
  logic            resp_hit, resp_multi, resp_alloc, resp_full;
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
  logic            resp_timeout;
`endif
  logic [LNC-1:0]  resp_index;
  logic [BW-1:0]   cell_address;
  logic            cell_valid, cell_wnr;
  logic [NC-1:0]   cell_set_address, cell_other_hit;
  logic [NC-1:0]   cell_hit, cell_decision_valid, cell_location_empty;
  logic [NC*BW-1:0] cell_rdata;
  logic [2:0]      dbg_state;

  logic [BW-1:0]   rd_arr [NC];
  logic [EW-1:0]   exp_q [$];
  int              tests_run = 0;
  int              tests_failed = 0;

  always #5 clk = ~clk;

  always_comb begin
    cell_rdata = '0;
    for (int i = 0; i < NC; i++) cell_rdata[i*BW +: BW] = rd_arr[i];
  end

  soft_mem_controller #(.BIT_WIDTH(BW), .NUM_CELLS(NC), .LOG_NUM_CELLS(LNC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wnr(req_wnr), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_hit(resp_hit), .resp_multi(resp_multi), .resp_alloc(resp_alloc), .resp_full(resp_full),
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
    .resp_timeout(resp_timeout),
`endif
    .resp_index(resp_index), .cell_address(cell_address), .cell_valid(cell_valid),
    .cell_wnr(cell_wnr), .cell_set_address(cell_set_address), .cell_other_hit(cell_other_hit),
    .cell_hit(cell_hit), .cell_decision_valid(cell_decision_valid),
    .cell_location_empty(cell_location_empty), .cell_rdata(cell_rdata),
    .dbg_state(dbg_state)
  );

  // Reference: response derived from the hit/empty rules alone.
  function automatic logic [EW-1:0] ref_model(input logic wnr, input logic [NC-1:0] hitm,
                                              input logic [NC-1:0] empm);
    int n_hit, first_hit, first_empty;
    logic h, m, a, f;
    logic [LNC-1:0] idx;
    logic [BW-1:0] d;
    n_hit = 0; first_hit = -1; first_empty = -1;
    for (int i = 0; i < NC; i++) begin
      if (hitm[i]) begin
        n_hit++;
        if (first_hit < 0) first_hit = i;
      end
      if (empm[i] && first_empty < 0) first_empty = i;
    end
    h = (n_hit > 0); m = (n_hit > 1); a = 1'b0; f = 1'b0; idx = '0; d = '0;
    if (h) begin
      idx = LNC'(first_hit);
      d   = rd_arr[first_hit];
    end else if (wnr) begin
      if (first_empty >= 0) begin
        a = 1'b1; idx = LNC'(first_empty);
      end else begin
        f = 1'b1;
      end
    end
    return {h, m, a, f, idx, d};
  endfunction

  // Expected cell_other_hit: cell i sees a hit iff some other cell hits.
  function automatic logic [NC-1:0] ref_other(input logic [NC-1:0] hitm);
    int n;
    logic [NC-1:0] r;
    n = 0;
    for (int i = 0; i < NC; i++) n += int'(hitm[i]);
    for (int i = 0; i < NC; i++) r[i] = (n - int'(hitm[i])) > 0;
    return r;
  endfunction

  function automatic logic [EW-1:0] observed();
    return {resp_hit, resp_multi, resp_alloc, resp_full, resp_index, resp_data};
  endfunction

  // One full transaction with the cell model answering one cycle after cell_valid.
  task automatic run_txn(input logic wnr, input logic [NC-1:0] hitm, input logic [NC-1:0] empm,
                         input int hold, input string tag);
    logic [EW-1:0] expv, got, held;
    logic [BW-1:0] addr;
    logic [NC-1:0] onehot;
    logic exp_alloc;
    expv = ref_model(wnr, hitm, empm);
    exp_q.push_back(expv);
    exp_alloc = expv[EW-3];
    addr = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_wnr = wnr; req_addr = addr;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = {$urandom, $urandom};
    @(negedge clk);
    tests_run++;
    if ({cell_valid, cell_wnr, cell_address} !== {1'b1, wnr, addr}) begin
      tests_failed++;
      $display("FAIL %s issue: got v=%b w=%b a=%h want v=1 w=%b a=%h", tag, cell_valid, cell_wnr, cell_address, wnr, addr);
    end
    @(posedge clk); #1;
    cell_decision_valid = '1; cell_hit = hitm; cell_location_empty = empm;
    @(negedge clk);
    tests_run++;
    if ({cell_other_hit, cell_valid, resp_valid} !== {ref_other(hitm), 2'b00}) begin
      tests_failed++;
      $display("FAIL %s decision_cycle: got oh=%b cv=%b rv=%b want oh=%b cv=0 rv=0", tag,
               cell_other_hit, cell_valid, resp_valid, ref_other(hitm));
    end
    @(posedge clk); #1;
    cell_decision_valid = '0; cell_hit = NC'($urandom); cell_location_empty = NC'($urandom);
    @(negedge clk);
    if (exp_alloc) begin
      onehot = '0;
      onehot[expv[EW-5 -: LNC]] = 1'b1;
      tests_run++;
      if ({cell_set_address, resp_valid, cell_address} !== {onehot, 1'b0, addr}) begin
        tests_failed++;
        $display("FAIL %s alloc_strobe: got sa=%b rv=%b a=%h want sa=%b rv=0 a=%h", tag,
                 cell_set_address, resp_valid, cell_address, onehot, addr);
      end
      @(negedge clk);
    end
    got = observed();
    expv = exp_q.pop_front();
    tests_run++;
    if ({resp_valid, cell_set_address, cell_other_hit, got} !== {1'b1, {2*NC{1'b0}}, expv}) begin
      tests_failed++;
      $display("FAIL %s response: got rv=%b sa=%b oh=%b fields=%h want rv=1 sa=0 oh=0 fields=%h", tag,
               resp_valid, cell_set_address, cell_other_hit, got, expv);
    end
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
    tests_run++;
    if (resp_timeout !== 1'b0) begin tests_failed++; $display("FAIL %s resp_timeout: got %b want 0", tag, resp_timeout); end
`endif
    held = got;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      tests_run++;
      if ({resp_valid, req_ready, observed()} !== {2'b10, held}) begin
        tests_failed++;
        $display("FAIL %s hold_%0d: got rv=%b rr=%b fields=%h want rv=1 rr=0 fields=%h", tag, k,
                 resp_valid, req_ready, observed(), held);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({resp_valid, req_ready, observed()} !== {2'b01, {EW{1'b0}}}) begin
      tests_failed++;
      $display("FAIL %s after_accept: got rv=%b rr=%b fields=%h want rv=0 rr=1 fields=0", tag,
               resp_valid, req_ready, observed());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_wnr = 1'b0; req_addr = '0; resp_ready = 1'b0;
    cell_hit = '0; cell_decision_valid = '0; cell_location_empty = '0;
    for (int i = 0; i < NC; i++) rd_arr[i] = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, cell_valid, cell_wnr, cell_set_address, cell_other_hit, dbg_state} !==
        {1'b1, 3'b000, {2*NC{1'b0}}, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got rr=%b rv=%b cv=%b cw=%b sa=%b oh=%b st=%0d want rr=1 others 0",
               req_ready, resp_valid, cell_valid, cell_wnr, cell_set_address, cell_other_hit, dbg_state);
    end
    tests_run++;
    if ({cell_address, observed()} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h fields=%h want 0", cell_address, observed());
    end
    rst = 1'b0;
  endtask

  task automatic test_write_alloc();
    for (int i = 0; i < NC; i++) rd_arr[i] = {8{8'hA5}};
    run_txn(1'b1, 4'b0000, 4'b1111, 0, "write_alloc");
  endtask

  task automatic test_read_hit();
    for (int i = 0; i < NC; i++) rd_arr[i] = {$urandom, $urandom};
    rd_arr[2] = {8{8'h3C}};
    run_txn(1'b0, 4'b0100, 4'b0000, 0, "read_hit");
  endtask

  task automatic test_write_multi();
    run_txn(1'b1, 4'b1010, 4'b0101, 0, "write_multi");
  endtask

  task automatic test_write_full();
    run_txn(1'b1, 4'b0000, 4'b0000, 0, "write_full");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 4'b0011, 4'b0000, 5, "hold5");
    run_txn(1'b0, 4'b0000, 4'b1111, 0, "read_miss");
  endtask

  task automatic test_ignore_decision();
    @(negedge clk);
    cell_decision_valid = '1; cell_hit = '1;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if ({req_ready, resp_valid, cell_other_hit, dbg_state} !== {2'b10, {NC{1'b0}}, 3'd0}) begin
        tests_failed++;
        $display("FAIL ignore_decision: got rr=%b rv=%b oh=%b st=%0d want rr=1 rv=0 oh=0 st=0",
                 req_ready, resp_valid, cell_other_hit, dbg_state);
      end
    end
    cell_decision_valid = '0; cell_hit = '0;
  endtask

  task automatic test_reset_in_alloc();
    @(negedge clk);
    req_valid = 1'b1; req_wnr = 1'b1; req_addr = {$urandom, $urandom};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    cell_decision_valid = '1; cell_hit = '0; cell_location_empty = 4'b0100;
    @(posedge clk); #1;
    cell_decision_valid = '0;
    @(negedge clk);
    tests_run++;
    if (cell_set_address !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rst_alloc_pre: got sa=%b want 0100", cell_set_address);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({cell_set_address, cell_valid, req_ready, resp_valid, cell_address} !== {{NC{1'b0}}, 3'b010, {BW{1'b0}}}) begin
      tests_failed++;
      $display("FAIL rst_alloc_now: got sa=%b cv=%b rr=%b rv=%b addr=%h want sa=0 cv=0 rr=1 rv=0 addr=0",
               cell_set_address, cell_valid, req_ready, resp_valid, cell_address);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({resp_valid, req_ready, cell_set_address, resp_alloc} !== {2'b01, {NC{1'b0}}, 1'b0}) begin
        tests_failed++;
        $display("FAIL rst_alloc_after: got rv=%b rr=%b sa=%b alloc=%b want rv=0 rr=1 sa=0 alloc=0",
                 resp_valid, req_ready, cell_set_address, resp_alloc);
      end
    end
  endtask

  task automatic test_no_decision();
    @(negedge clk);
    req_valid = 1'b1; req_wnr = 1'b0; req_addr = {$urandom, $urandom};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
`ifdef SOFT_MEM_CTRL_TIMEOUT_EN
    repeat (14) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: got rv=%b want 0", resp_valid); end
    @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_timeout, resp_hit, resp_full} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL timeout_resp: got rv=%b to=%b hit=%b full=%b want 1 1 0 0", resp_valid, resp_timeout, resp_hit, resp_full);
    end
`else
    repeat (20) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({resp_valid, dbg_state} !== {1'b0, 3'd2}) begin
      tests_failed++;
      $display("FAIL wait_forever: got rv=%b st=%0d want rv=0 st=2", resp_valid, dbg_state);
    end
    @(posedge clk); #1;
    cell_decision_valid = '1; cell_hit = '0; cell_location_empty = '1;
    @(posedge clk); #1;
    cell_decision_valid = '0;
    @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_hit, resp_data} !== {2'b10, {BW{1'b0}}}) begin
      tests_failed++;
      $display("FAIL late_decision: got rv=%b hit=%b data=%h want rv=1 hit=0 data=0", resp_valid, resp_hit, resp_data);
    end
`endif
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [NC-1:0] hitm;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NC; i++) rd_arr[i] = {$urandom, $urandom};
      hitm = ($urandom_range(0, 2) == 0) ? NC'(0) : NC'($urandom_range(0, 15));
      run_txn(1'($urandom_range(0, 1)), hitm, NC'($urandom_range(0, 15)), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_alloc();
    test_read_hit();
    test_write_multi();
    test_write_full();
    test_back_to_back();
    test_ignore_decision();
    test_reset_in_alloc();
    test_no_decision();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
